// File: rtl/rate_ctrl_pkg.sv
// rate_ctrl shared definitions
// FSM encodings and divisor floor
package rate_ctrl_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/period_counter.sv
// Reloadable down-counter for the period timebase
// Reloads on the enabled cycle where it sits at zero
module period_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] reload_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign zero_o = (cnt_q == '0);
  assign cnt_o  = cnt_q;

  // Decrement when enabled, reload from zero
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = zero_o ? reload_i : cnt_q - W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rate_ctrl.sv
// Run-time sample-rate controller
// Glitch-free divisor changes, start/stop, bursts
module rate_ctrl
  import rate_ctrl_defs::*;
#(
  parameter int W       = 16,
  parameter int BW      = 8,
  parameter int DIV_RST = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [BW-1:0] burst_len,
  input  logic [W-1:0]  div_in,
  input  logic          div_valid,
  output logic          div_ready,
  output logic          tick,
  output logic          slow,
  output logic          busy,
  output logic          done,
  output logic [BW-1:0] tick_cnt
);

  state_e        state_q;
  logic [W-1:0]  div_act_q;
  logic [W-1:0]  shadow_q;
  logic          pend_q;
  logic [BW-1:0] burst_q;
  logic [BW-1:0] tick_cnt_q;
  logic          done_q;

  logic [W-1:0]  cnt;
  logic          zero;
  logic          start_go;
  logic          xfer;
  logic          final_tick;
  logic          exit_run;
  logic [W-1:0]  div_clamp;
  logic [W-1:0]  per_len;
  logic [W-1:0]  reload_d;

  assign busy      = (state_q != IDLE);
  assign tick      = busy && zero;
  assign slow      = busy && (cnt < (div_act_q >> 1));
  assign div_ready = !pend_q;
  assign done      = done_q;
  assign tick_cnt  = tick_cnt_q;

  assign start_go = (state_q == IDLE)
                  && start && !stop;
  assign xfer     = div_valid && div_ready;

  assign div_clamp = (div_in < W'(MIN_DIV))
                   ? W'(MIN_DIV) : div_in;

  assign final_tick = (burst_q != '0)
    && ((tick_cnt_q + BW'(1)) == burst_q);

  // Tick that ends the run in either busy state
  assign exit_run = tick
    && ((state_q == STOP)
     || (state_q == RUN
         && (stop || final_tick)));

  // Length of the period that follows this reload
  always_comb begin
    per_len = div_act_q;
    if (!busy) begin
      per_len = xfer ? div_clamp : div_act_q;
    end else if (pend_q) begin
      per_len = shadow_q;
    end
    reload_d = exit_run ? '0 : per_len - W'(1);
  end

  period_counter #(
    .W (W)
  ) u_per (
    .clk      (clk),
    .rst_n    (rst),
    .en_i     (busy || start_go),
    .reload_i (reload_d),
    .cnt_o    (cnt),
    .zero_o   (zero)
  );

  // FSM, divisor handshake and burst bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      div_act_q  <= W'(DIV_RST);
      shadow_q   <= '0;
      pend_q     <= 1'b0;
      burst_q    <= '0;
      tick_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= exit_run && final_tick;

      unique case (state_q)
        IDLE: begin
          if (start_go) begin
            state_q    <= RUN;
            burst_q    <= burst_len;
            tick_cnt_q <= '0;
          end
        end
        RUN: begin
          if (exit_run) begin
            state_q <= IDLE;
          end else if (stop) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (exit_run) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (tick) begin
        tick_cnt_q <= tick_cnt_q + BW'(1);
      end

      if (tick && pend_q) begin
        div_act_q <= shadow_q;
        pend_q    <= 1'b0;
      end

      if (xfer) begin
        if (!busy || exit_run) begin
          div_act_q <= div_clamp;
        end else begin
          shadow_q <= div_clamp;
          pend_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rate_ctrl.sv
// Directed bench for rate_ctrl
// Hand-derived cycle expectations, DIV_RST=4
module tb_rate_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [7:0]  burst_len;
  logic [15:0] div_in;
  logic        div_valid;
  logic        div_ready;
  logic        tick;
  logic        slow;
  logic        busy;
  logic        done;
  logic [7:0]  tick_cnt;

  int n_cmp = 0;
  int n_err = 0;

  rate_ctrl #(
    .W       (16),
    .BW      (8),
    .DIV_RST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .tick      (tick),
    .slow      (slow),
    .busy      (busy),
    .done      (done),
    .tick_cnt  (tick_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input logic [15:0] v);
    div_in    = v;
    div_valid = 1'b1;
    nxt();
    div_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] n);
    burst_len = n;
    start     = 1'b1;
    nxt();
    start     = 1'b0;
  endtask

  task automatic chk_rst(input string t);
    chk({t, " tick"}, 32'(tick), 0);
    chk({t, " slow"}, 32'(slow), 0);
    chk({t, " busy"}, 32'(busy), 0);
    chk({t, " done"}, 32'(done), 0);
    chk({t, " rdy"}, 32'(div_ready), 1);
    chk({t, " tcnt"}, 32'(tick_cnt), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    burst_len = '0;
    div_in    = '0;
    div_valid = 1'b0;
    #3 rst = 1'b0;
    #10;
    chk_rst("rst");
    @(posedge clk);
    #1 rst = 1'b1;
    nxt();
    chk_rst("post");

    // continuous div=4
    do_start(8'd0);
    for (int k = 1; k <= 12; k++) begin
      chk($sformatf("t1 tick k%0d", k),
          32'(tick), 32'(k % 4 == 0));
      chk($sformatf("t1 slow k%0d", k),
          32'(slow),
          32'((k % 4 == 3) || (k % 4 == 0)));
      chk($sformatf("t1 busy k%0d", k),
          32'(busy), 1);
      if (k < 12) nxt();
    end
    chk("t1 tcnt12", 32'(tick_cnt), 2);
    stop = 1'b1;
    nxt();
    stop = 1'b0;
    chk("t1 idle busy", 32'(busy), 0);
    chk("t1 idle tick", 32'(tick), 0);
    chk("t1 idle slow", 32'(slow), 0);
    chk("t1 idle done", 32'(done), 0);
    chk("t1 idle tcnt", 32'(tick_cnt), 3);

    // divisor change 4 -> 6 mid-run
    do_start(8'd0);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("t2 tick k%0d", k),
          32'(tick),
          32'(k == 4 || k == 10 || k == 16));
      chk($sformatf("t2 rdy k%0d", k),
          32'(div_ready),
          32'(!(k == 3 || k == 4)));
      chk($sformatf("t2 slow k%0d", k),
          32'(slow),
          (k >= 5) ? 32'((k - 5) % 6 >= 3)
                   : 32'(k == 3 || k == 4));
      if (k == 2) begin
        div_in    = 16'd6;
        div_valid = 1'b1;
      end
      if (k == 3) div_valid = 1'b0;
      if (k == 16) stop = 1'b1;
      nxt();
    end
    stop = 1'b0;
    chk("t2 idle busy", 32'(busy), 0);

    // burst of 3 at div=5
    load_idle(16'd5);
    chk("t3 rdy", 32'(div_ready), 1);
    do_start(8'd3);
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("t3 tick k%0d", k),
          32'(tick),
          32'(k % 5 == 0 && k <= 15));
      chk($sformatf("t3 busy k%0d", k),
          32'(busy), 32'(k <= 15));
      chk($sformatf("t3 done k%0d", k),
          32'(done), 32'(k == 16));
      if (k == 16)
        chk("t3 tcnt", 32'(tick_cnt), 3);
      if (k < 17) nxt();
    end

    // stop request mid-period at div=8
    load_idle(16'd8);
    do_start(8'd0);
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("t4 tick k%0d", k),
          32'(tick), 32'(k == 8));
      chk($sformatf("t4 busy k%0d", k),
          32'(busy), 32'(k <= 8));
      chk($sformatf("t4 done k%0d", k),
          32'(done), 0);
      if (k == 2) stop = 1'b1;
      if (k == 3) stop = 1'b0;
      if (k < 9) nxt();
    end
    start = 1'b1;
    stop  = 1'b1;
    nxt();
    start = 1'b0;
    stop  = 1'b0;
    chk("t4 ss busy0", 32'(busy), 0);
    nxt();
    chk("t4 ss busy1", 32'(busy), 0);
    chk("t4 ss tick", 32'(tick), 0);

    // clamp: div_in=1 then div_in=0
    load_idle(16'd1);
    do_start(8'd0);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("t5a tick k%0d", k),
          32'(tick), 32'(k % 2 == 0));
      chk($sformatf("t5a slow k%0d", k),
          32'(slow), 32'(k % 2 == 0));
      if (k == 6) stop = 1'b1;
      nxt();
    end
    stop = 1'b0;
    chk("t5a idle", 32'(busy), 0);
    load_idle(16'd0);
    do_start(8'd0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t5b tick k%0d", k),
          32'(tick), 32'(k % 2 == 0));
      chk($sformatf("t5b slow k%0d", k),
          32'(slow), 32'(k % 2 == 0));
      if (k == 4) stop = 1'b1;
      nxt();
    end
    stop = 1'b0;

    // async reset mid-burst
    load_idle(16'd6);
    do_start(8'd5);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("t6 tick k%0d", k),
          32'(tick), 32'(k == 6 || k == 12));
      if (k == 14) begin
        div_in    = 16'd9;
        div_valid = 1'b1;
      end
      if (k == 15) div_valid = 1'b0;
      if (k < 16) nxt();
    end
    chk("t6 pre slow", 32'(slow), 1);
    chk("t6 pre tcnt", 32'(tick_cnt), 2);
    chk("t6 pre rdy", 32'(div_ready), 0);
    chk("t6 pre busy", 32'(busy), 1);
    rst = 1'b0;
    #2;
    chk_rst("t6 rst");
    rst = 1'b1;
    nxt();
    chk("t6 after busy", 32'(busy), 0);
    do_start(8'd0);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t6r tick k%0d", k),
          32'(tick), 32'(k % 4 == 0));
      if (k == 8) stop = 1'b1;
      nxt();
    end
    stop = 1'b0;
    chk("t6r idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rate_ctrl.md
# rate_ctrl

Run-time controller for the generator's sample-rate timebase. Replaces the fixed-divisor divider wherever the rate must change while running. Produces a one-cycle `tick` enable and a square-wave `slow` from `clk`. Adds start/stop sequencing, finite bursts, and a valid/ready divisor-load port whose new value takes effect only on a period boundary, so periods never glitch. Sits between the control/UI logic and the waveform datapath; downstream logic uses `tick` as a clock enable and never as a clock.

## Interface
- `W`, 16: divisor width.
- `BW`, 8: burst-length and tick-count width.
- `DIV_RST`, 50000: active divisor after reset. Must satisfy 2 ≤ `DIV_RST` < 2^W.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: level, sampled in IDLE; begins run.
- `stop` in 1: level; requests stop at end of current period.
- `burst_len` in BW: number of ticks per run, sampled with `start`; 0 means continuous.
- `div_in` in W: requested divisor (period in `clk` cycles).
- `div_valid` in 1: `div_in` valid.
- `div_ready` out 1: divisor shadow register empty.
- `tick` out 1: one-cycle pulse on the last cycle of each period.
- `slow` out 1: square wave, one period per `tick`.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after the final tick of a finite burst.
- `tick_cnt` out BW: ticks issued in the current run.

## Operation
- FSM states:
  - IDLE: start → RUN; stop dominates, so start and stop together leave the FSM in IDLE.
  - RUN: stop → STOP; final burst tick → IDLE.
  - STOP: the next tick → IDLE.
- Registers: state, `cnt`[W], `div_act`[W], `shadow`[W], `pend`, `burst`[BW], `tick_cnt`, `done`.
- Divisor clamp: any loaded value below 2 becomes 2.
- Period counter:
  - On entry to RUN, `cnt` ← `div_act`−1.
  - While busy, `cnt` decrements each cycle.
  - At `cnt`==0 it reloads with the next period length.
  - In IDLE, `cnt` holds 0.
- `tick` = busy && `cnt`==0. Decoded from registers only; no input-to-output combinational path.
- `slow` = busy && (`cnt` < (`div_act`>>1)).
  - Low for ceil(div/2) cycles, then high for floor(div/2) cycles.
  - The last high cycle coincides with `tick`.
- Divisor load:
  - A transfer happens when `div_valid` && `div_ready` at a rising edge.
  - In IDLE: `div_act` ← clamp(`div_in`) directly; `pend` stays 0.
  - While busy: `shadow` ← clamp(`div_in`), `pend` ← 1, so `div_ready` drops.
  - `div_ready` = !`pend`.
  - At the next tick: `div_act` ← `shadow`, `cnt` ← `shadow`−1, `pend` ← 0.
  - If `pend` is still set on return to IDLE, `div_act` ← `shadow` and `pend` clears on that same edge.
- Burst:
  - `tick_cnt` clears on start and increments on each tick; in continuous mode it wraps at 2^BW.
  - With `burst_len`=N>0, the N-th tick moves RUN→IDLE and sets `done` for one cycle.
  - A stop-forced exit does not pulse `done`, except when the stop tick is also the N-th tick.
- `start` while busy is ignored. `stop` while in STOP or IDLE is ignored.

## Timing
- Reset values:
  - `tick`=0, `slow`=0, `busy`=0, `done`=0, `div_ready`=1, `tick_cnt`=0.
  - Internally: `div_act`=`DIV_RST`, `pend`=0, state=IDLE.
- Start latency: start sampled at edge E0 → `busy`=1 after E0. First `tick` is in the div-th cycle after E0, then every div cycles.
- Divisor change: periods already under way complete with the old value. The first period after the next tick uses the new value. No period is ever a mix of old and new.
- Stop: `busy` falls on the edge that ends the tick cycle. `slow` and `tick` are 0 from then on.
- `done`: high in the first IDLE cycle after the final burst tick.
- Reset asserted mid-run forces all reset values immediately (asynchronous). Deassertion is synchronized externally.

## Structure
- Shared package/header `rate_ctrl_defs`: state encodings IDLE=2'd0, RUN=2'd1, STOP=2'd2, plus constant MIN_DIV=2.
- Sub-module `period_counter`: W-bit reloadable down-counter. Inputs: enable and reload value. Outputs: `cnt` and `zero`.
- The FSM, handshake and burst logic stay in the top level.

## Test plan
- Reset, then `DIV_RST`=4, start, `burst_len`=0 → `tick` in cycles 4, 8, 12 after start; `slow` pattern 0,0,1,1 repeating.
- `div_in`=6 accepted in cycle 2 of a div=4 run → `div_ready` low until the tick in cycle 4; next ticks at cycles 10 and 16.
- `burst_len`=3, div=5, start → 3 ticks at cycles 5, 10, 15; `done` pulses at cycle 16; `busy`=0 and `tick_cnt`=3.
- `stop` in cycle 2 of a div=8 run → tick at cycle 8, then IDLE with `done`=0. `start` and `stop` together in IDLE → `busy` stays 0.
- `div_in`=0 and `div_in`=1 loaded in IDLE → period of 2: ticks every 2nd cycle, `slow` toggles each cycle.
- `rst` low in the middle of a burst → all outputs at reset values on the same cycle; a restart uses `DIV_RST`.
